// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: H/V counters, syncs, visible flag, line/frame strobes.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned P_H_CNT_WIDTH     = 10,
  parameter int unsigned P_V_CNT_WIDTH     = 10,
  parameter int unsigned P_H_VISIBLE       = 640,
  parameter int unsigned P_H_FRONT_PORCH   = 16,
  parameter int unsigned P_H_SYNC          = 96,
  parameter int unsigned P_H_BACK_PORCH    = 48,
  parameter int unsigned P_V_VISIBLE       = 480,
  parameter int unsigned P_V_FRONT_PORCH   = 10,
  parameter int unsigned P_V_SYNC          = 2,
  parameter int unsigned P_V_BACK_PORCH    = 33,
  parameter bit          P_H_SYNC_POL      = 1'b0,
  parameter bit          P_V_SYNC_POL      = 1'b0,
  parameter int unsigned P_FRAME_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_pix_en,
  output logic [P_H_CNT_WIDTH-1:0] oa_h_coord,
  output logic [P_V_CNT_WIDTH-1:0] oa_v_coord,
  output logic                     o_visible,
  output logic                     o_h_sync,
  output logic                     o_v_sync,
  output logic                     o_line_start,
  output logic                     o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [P_FRAME_CNT_WIDTH-1:0] oa_frame_cnt
`endif
);

  localparam int unsigned H_TOTAL      = P_H_VISIBLE + P_H_FRONT_PORCH + P_H_SYNC + P_H_BACK_PORCH;
  localparam int unsigned V_TOTAL      = P_V_VISIBLE + P_V_FRONT_PORCH + P_V_SYNC + P_V_BACK_PORCH;
  localparam int unsigned H_SYNC_START = P_H_VISIBLE + P_H_FRONT_PORCH;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + P_H_SYNC;
  localparam int unsigned V_SYNC_START = P_V_VISIBLE + P_V_FRONT_PORCH;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + P_V_SYNC;

  localparam longint unsigned H_CAP = 64'd1 << P_H_CNT_WIDTH;
  localparam longint unsigned V_CAP = 64'd1 << P_V_CNT_WIDTH;

  localparam logic [P_H_CNT_WIDTH-1:0] H_LAST = P_H_CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [P_V_CNT_WIDTH-1:0] V_LAST = P_V_CNT_WIDTH'(V_TOTAL - 1);

  // Configuration sanity: totals must fit their counters, segments must be non-empty where required.
  if (64'(H_TOTAL) > H_CAP || 64'(V_TOTAL) > V_CAP ||
      P_H_VISIBLE < 1 || P_V_VISIBLE < 1 || P_H_SYNC < 1 || P_V_SYNC < 1 ||
      P_FRAME_CNT_WIDTH < 1) begin : g_bad_config
    initial begin
      $display("vga_timing_gen: illegal parameters (H_TOTAL=%0d, V_TOTAL=%0d)", H_TOTAL, V_TOTAL);
      $finish;
    end
  end

  logic [P_H_CNT_WIDTH-1:0] h_q;
  logic [P_V_CNT_WIDTH-1:0] v_q;
  logic [P_H_CNT_WIDTH-1:0] h_next;
  logic [P_V_CNT_WIDTH-1:0] v_next;
  logic                     h_wrap;
  logic                     v_wrap;
  logic                     visible_next;
  logic                     h_sync_act;
  logic                     v_sync_act;

  // Raster advance: one pixel per enabled cycle, line advance on h wrap.
  always_comb begin
    h_next = h_q;
    v_next = v_q;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (i_pix_en) begin
      if (h_q == H_LAST) begin
        h_next = '0;
        h_wrap = 1'b1;
        if (v_q == V_LAST) begin
          v_next = '0;
          v_wrap = 1'b1;
        end else begin
          v_next = v_q + P_V_CNT_WIDTH'(1);
        end
      end else begin
        h_next = h_q + P_H_CNT_WIDTH'(1);
      end
    end
  end

  // Flags derived from next-state coordinates so they line up with the registered coordinates.
  always_comb begin
    visible_next = (32'(h_next) < P_H_VISIBLE) && (32'(v_next) < P_V_VISIBLE);
    h_sync_act   = (32'(h_next) >= H_SYNC_START) && (32'(h_next) < H_SYNC_END);
    v_sync_act   = (32'(v_next) >= V_SYNC_START) && (32'(v_next) < V_SYNC_END);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      h_q           <= '0;
      v_q           <= '0;
      o_visible     <= 1'b1;
      o_h_sync      <= ~P_H_SYNC_POL;
      o_v_sync      <= ~P_V_SYNC_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      h_q           <= h_next;
      v_q           <= v_next;
      o_visible     <= visible_next;
      o_h_sync      <= h_sync_act ? P_H_SYNC_POL : ~P_H_SYNC_POL;
      o_v_sync      <= v_sync_act ? P_V_SYNC_POL : ~P_V_SYNC_POL;
      o_line_start  <= h_wrap;
      o_frame_start <= v_wrap;
    end
  end

  assign oa_h_coord = h_q;
  assign oa_v_coord = v_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [P_FRAME_CNT_WIDTH-1:0] frame_cnt_q;

  // Frame counter steps on the same edge that raises o_frame_start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + P_FRAME_CNT_WIDTH'(1);
    end
  end

  assign oa_frame_cnt = frame_cnt_q;
`endif

endmodule
